// File: rtl/jtbubl_linebuf_if.sv
// Scan-out, renderer-write and status signals shared between the object line buffer and its neighbours.
interface jtbubl_linebuf_if #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 8
);
  logic          pxl_cen;
  logic          LHBL;
  logic          LVBL;
  logic [AW-1:0] hdump;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_bank;
  logic          line_done;
  logic [DW-1:0] col_addr;

  modport master (
    output pxl_cen, LHBL, LVBL, hdump, wr_en, wr_addr, wr_data,
    input  wr_bank, line_done, col_addr
  );

  modport slave (
    input  pxl_cen, LHBL, LVBL, hdump, wr_en, wr_addr, wr_data,
    output wr_bank, line_done, col_addr
  );
endinterface

// File: rtl/jtbubl_linebuf.sv
// Double-buffered object line buffer: renderer fills the back bank while the front
// bank is scanned out and erased pixel by pixel; banks swap on each LHBL falling edge.
module jtbubl_linebuf #(
  parameter int unsigned   AW     = 8,
  parameter int unsigned   DW     = 8,
  parameter logic [3:0]    TRANSP = 4'hF,
  parameter logic [DW-1:0] BLANK  = '1
) (
  input  logic             clk,
  input  logic             rst_n,
  jtbubl_linebuf_if.slave  bus
);
  localparam int unsigned NPIX = 1 << AW;

  logic [DW-1:0] mem0 [NPIX];
  logic [DW-1:0] mem1 [NPIX];

  logic          back_q, back_d;
  logic          lhbl_q, lhbl_d;
  logic          line_done_q, line_done_d;
  logic [DW-1:0] col_addr_q, col_addr_d;

  logic          wr0, wr1, erase0, erase1;
  logic [DW-1:0] front_rd;

  // Swap detection, renderer write steering and scan-out/erase selection
  always_comb begin
    back_d      = back_q;
    lhbl_d      = bus.LHBL;
    line_done_d = 1'b0;
    col_addr_d  = col_addr_q;
    wr0         = 1'b0;
    wr1         = 1'b0;
    erase0      = 1'b0;
    erase1      = 1'b0;
    front_rd    = back_q ? mem0[bus.hdump] : mem1[bus.hdump];

    if (lhbl_q && !bus.LHBL) begin
      back_d      = ~back_q;
      line_done_d = 1'b1;
    end

    // Steered by the pre-swap back bank, so a write on the swap clk lands in the old back bank
    if (bus.wr_en && (bus.wr_data[3:0] != TRANSP)) begin
      wr0 = ~back_q;
      wr1 = back_q;
    end

    if (bus.pxl_cen) begin
      if (bus.LHBL && bus.LVBL) begin
        col_addr_d = front_rd;
        erase0     = back_q;
        erase1     = ~back_q;
      end else begin
        col_addr_d = BLANK;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      back_q      <= 1'b1;
      lhbl_q      <= 1'b1;
      line_done_q <= 1'b0;
      col_addr_q  <= BLANK;
    end else begin
      back_q      <= back_d;
      lhbl_q      <= lhbl_d;
      line_done_q <= line_done_d;
      col_addr_q  <= col_addr_d;
    end
  end

  // RAM contents are not reset; renderer write and erase always hit opposite banks
  always_ff @(posedge clk) begin
    if (wr0)    mem0[bus.wr_addr] <= bus.wr_data;
    if (erase0) mem0[bus.hdump]   <= BLANK;
    if (wr1)    mem1[bus.wr_addr] <= bus.wr_data;
    if (erase1) mem1[bus.hdump]   <= BLANK;
  end

  assign bus.wr_bank   = back_q;
  assign bus.line_done = line_done_q;
  assign bus.col_addr  = col_addr_q;
endmodule

// File: tb/tb_jtbubl_linebuf.sv
// Directed bench for jtbubl_linebuf: bank swaps, write/transparency rules, erase-on-read, blanking, reset.
module tb_jtbubl_linebuf;
  logic clk;
  logic rst_n;
  int   n_chk  = 0;
  int   n_pass = 0;
  logic exp_back;

  jtbubl_linebuf_if bus ();

  jtbubl_linebuf dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic wr(input int addr, input logic [7:0] data);
    @(negedge clk);
    bus.wr_en   = 1'b1;
    bus.wr_addr = 8'(addr);
    bus.wr_data = data;
    @(negedge clk);
    bus.wr_en   = 1'b0;
  endtask

  // LHBL low for a few clocks; optional renderer write on the falling-edge clk
  task automatic swap(input string tag, input bit do_wr = 1'b0, input int addr = 0,
                      input logic [7:0] data = 8'h00);
    @(negedge clk);
    bus.LHBL = 1'b0;
    if (do_wr) begin
      bus.wr_en   = 1'b1;
      bus.wr_addr = 8'(addr);
      bus.wr_data = data;
    end
    exp_back = ~exp_back;
    @(negedge clk);
    bus.wr_en = 1'b0;
    chk({tag, "_ld_hi"}, 32'(bus.line_done), 32'd1);
    chk({tag, "_bank"},  32'(bus.wr_bank),   32'(exp_back));
    @(negedge clk);
    chk({tag, "_ld_lo"}, 32'(bus.line_done), 32'd0);
    repeat (2) @(negedge clk);
    bus.LHBL = 1'b1;
    @(negedge clk);
    chk({tag, "_ld_rise"}, 32'(bus.line_done), 32'd0);
  endtask

  // Scan pixels 0..last; each pixel: one pxl_cen clk, then one idle clk to check hold
  task automatic scan(input string tag, input bit do_chk, input bit lvbl,
                      input int a0 = -1, input logic [7:0] e0 = 8'hFF,
                      input int a1 = -1, input logic [7:0] e1 = 8'hFF,
                      input int last = 255);
    int bad;
    logic [7:0] v, v2;
    bad = 0;
    bus.LVBL = lvbl;
    for (int h = 0; h <= last; h++) begin
      @(negedge clk);
      bus.hdump   = 8'(h);
      bus.pxl_cen = 1'b1;
      @(negedge clk);
      bus.pxl_cen = 1'b0;
      v = bus.col_addr;
      @(negedge clk);
      v2 = bus.col_addr;
      if (do_chk) begin
        if (h == a0) begin
          chk({tag, "_a0"},      32'(v),  32'(e0));
          chk({tag, "_a0_hold"}, 32'(v2), 32'(e0));
        end else if (h == a1) begin
          chk({tag, "_a1"},      32'(v),  32'(e1));
          chk({tag, "_a1_hold"}, 32'(v2), 32'(e1));
        end else if (v !== 8'hFF || v2 !== 8'hFF) begin
          bad++;
        end
      end
    end
    bus.LVBL = 1'b1;
    if (do_chk) chk({tag, "_rest_blank"}, 32'(bad), 32'd0);
  endtask

  initial begin
    bus.pxl_cen = 1'b0;
    bus.LHBL    = 1'b1;
    bus.LVBL    = 1'b1;
    bus.hdump   = 8'd0;
    bus.wr_en   = 1'b0;
    bus.wr_addr = 8'd0;
    bus.wr_data = 8'd0;
    exp_back    = 1'b1;
    rst_n       = 1'b1;
    #3 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_col",  32'(bus.col_addr),  32'hFF);
    chk("rst_bank", 32'(bus.wr_bank),   32'd1);
    chk("rst_ld",   32'(bus.line_done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Flush both banks so their contents are known blank
    scan("clr0", 1'b0, 1'b1);
    swap("sw_clr0");
    scan("clr1", 1'b0, 1'b1);
    swap("sw_clr1");

    // Single pixel shows one pxl_cen after its hdump
    wr(10, 8'h35);
    swap("sw_t2");
    scan("t2", 1'b1, 1'b1, 10, 8'h35);

    // Same bank two swaps later has been erased by the previous scan
    swap("sw_t3a");
    scan("t3a", 1'b1, 1'b1);
    swap("sw_t3b");
    scan("t3", 1'b1, 1'b1, 10, 8'hFF);

    // Transparent pen dropped; opaque overwrite wins
    wr(20, 8'h35);
    wr(20, 8'h2F);
    wr(30, 8'h35);
    wr(30, 8'h41);
    swap("sw_t4");
    scan("t4", 1'b1, 1'b1, 20, 8'h35, 30, 8'h41);

    // Write on the swap clk lands in the bank displayed right after the swap
    swap("sw_t5", 1'b1, 40, 8'h57);
    scan("t5", 1'b1, 1'b1, 40, 8'h57);

    // Vertical blank hides data without erasing it
    wr(50, 8'h63);
    swap("sw_t6a");
    scan("t6_vbl", 1'b1, 1'b0, 50, 8'hFF);
    swap("sw_t6b");
    scan("t6_other", 1'b0, 1'b1);
    swap("sw_t6c");
    scan("t6", 1'b1, 1'b1, 50, 8'h63);

    // Asynchronous reset in the middle of a line
    wr(70, 8'h24);
    swap("sw_t7");
    scan("t7_part", 1'b1, 1'b1, 70, 8'h24, -1, 8'hFF, 70);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_col",  32'(bus.col_addr),  32'hFF);
    chk("mid_rst_bank", 32'(bus.wr_bank),   32'd1);
    chk("mid_rst_ld",   32'(bus.line_done), 32'd0);
    @(negedge clk);
    rst_n    = 1'b1;
    exp_back = 1'b1;
    swap("sw_post_rst");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
